// File: rtl/gate_tt_checker_if.sv
// gate_tt_checker_if: stimulus, gate-result and run-status signals of the truth-table checker
interface gate_tt_checker_if;
  logic       start;
  logic       a;
  logic       b;
  logic [2:0] y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] err_mask;
  logic [1:0] vec_idx;
  modport master (
    output start, y_in,
    input  a, b, busy, done, pass, err_count, err_mask, vec_idx
  );
  modport slave (
    input  start, y_in,
    output a, b, busy, done, pass, err_count, err_mask, vec_idx
  );
endinterface

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: walks a 2-input AND/OR/NOT block through its truth table and scores each result
module gate_tt_checker #(
  parameter int HOLD_CYCLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  gate_tt_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       last;
  logic       mis;
  assign last = cnt == 8'(HOLD_CYCLES - 1);
  // expected result comes from the registered stimulus, never from y_in itself
  assign mis = bus.y_in != {bus.a & bus.b, bus.a | bus.b, ~bus.a};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (bus.start ? DRIVE : IDLE) :
               state == DRIVE ? ((last && &bus.vec_idx) ? DONE : DRIVE) : IDLE;
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt           <= '0;
      bus.vec_idx   <= '0;
      bus.a         <= 1'b0;
      bus.b         <= 1'b0;
      bus.err_count <= '0;
      bus.err_mask  <= '0;
      bus.pass      <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        cnt           <= '0;
        bus.vec_idx   <= '0;
        bus.a         <= 1'b0;
        bus.b         <= 1'b0;
        bus.err_count <= '0;
        bus.err_mask  <= '0;
      end
    end else if (state == DRIVE) begin
      if (last) begin
        if (mis) begin
          bus.err_count              <= bus.err_count + 3'd1;
          bus.err_mask[bus.vec_idx] <= 1'b1;
        end
        if (&bus.vec_idx) bus.pass <= bus.err_count == 3'd0 && !mis;
        else begin
          cnt          <= '0;
          bus.vec_idx  <= bus.vec_idx + 2'd1;
          {bus.a, bus.b} <= bus.vec_idx + 2'd1;
        end
      end else cnt <= cnt + 8'd1;
    end else begin
      bus.a <= 1'b0;
      bus.b <= 1'b0;
    end
endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: randomized runs on H=4 and H=1 checkers against a cycle-offset reference model
module tb_gate_tt_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  gate_tt_checker_if bus0 ();
  gate_tt_checker_if bus1 ();
  gate_tt_checker #(.HOLD_CYCLES(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  gate_tt_checker #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  logic       start_i[2];
  logic [2:0] ftab[2][4];
  logic [2:0] junk[2];
  logic [2:0] yv[2];
  logic       a_o[2], b_o[2], busy_o[2], done_o[2], pass_o[2];
  logic [2:0] ec_o[2];
  logic [3:0] em_o[2];
  logic [1:0] vi_o[2];
  assign bus0.start = start_i[0];
  assign bus1.start = start_i[1];
  assign bus0.y_in  = yv[0];
  assign bus1.y_in  = yv[1];
  assign {a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0]} = {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass};
  assign {a_o[1], b_o[1], busy_o[1], done_o[1], pass_o[1]} = {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass};
  assign {ec_o[0], em_o[0], vi_o[0]} = {bus0.err_count, bus0.err_mask, bus0.vec_idx};
  assign {ec_o[1], em_o[1], vi_o[1]} = {bus1.err_count, bus1.err_mask, bus1.vec_idx};
  function automatic int hold(input int g);
    return g == 0 ? 4 : 1;
  endfunction
  function automatic logic [2:0] gold(input int v);
    logic [1:0] ab;
    ab = 2'(v);
    return {ab[1] & ab[0], ab[1] | ab[0], ~ab[1]};
  endfunction
  function automatic logic [3:0] fail_of(input int g);
    logic [3:0] f;
    for (int v = 0; v < 4; v++) f[v] = ftab[g][v] != gold(v);
    return f;
  endfunction
  // reference: a run is just "k edges since start was accepted"
  logic       run[2];
  int         k[2];
  logic [3:0] fails[2], mask_l[2];
  logic       pass_l[2];
  logic [1:0] vid_l[2];
  // y_in is garbage except on the edge that samples it
  for (genvar g = 0; g < 2; g++) begin : w
    assign yv[g] = (run[g] && ((k[g] + 1) % hold(g)) != 0) ? junk[g] : ftab[g][{a_o[g], b_o[g]}];
  end
  always @(posedge clk or negedge rst_n)
    for (int g = 0; g < 2; g++)
      if (!rst_n) begin
        run[g] <= 1'b0; k[g] <= 0; fails[g] <= '0; mask_l[g] <= '0;
        pass_l[g] <= 1'b0; vid_l[g] <= '0; junk[g] <= '0;
      end else begin
        junk[g] <= 3'($urandom);
        if (!run[g]) begin
          if (start_i[g]) begin
            run[g] <= 1'b1; k[g] <= 0; fails[g] <= fail_of(g);
          end
        end else if (k[g] == 4 * hold(g)) begin
          run[g] <= 1'b0; mask_l[g] <= fails[g]; pass_l[g] <= fails[g] == 4'd0; vid_l[g] <= 2'd3;
        end else k[g] <= k[g] + 1;
      end
  int nvec = 0, nmis = 0, tmo = 0;
  logic fin_req = 1'b0;
  logic lit_en[2];
  int   lit_mask[2], lit_cnt[2], lit_pass[2], lit_lat[2];
  function automatic void chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  int         h, kk, n;
  logic [1:0] v;
  logic [3:0] m;
  logic       ea, eb, ebusy, edone, epass;
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      h = hold(g);
      kk = k[g];
      if (run[g]) begin
        v = kk < 4 * h ? 2'(kk / h) : 2'd3;
        n = kk / h > 4 ? 4 : kk / h;
        m = fails[g] & 4'((1 << n) - 1);
        {ea, eb, ebusy, edone} = {v[1], v[0], 1'b1, kk == 4 * h};
        epass = kk >= 4 * h ? fails[g] == 4'd0 : pass_l[g];
      end else begin
        v = vid_l[g];
        m = mask_l[g];
        {ea, eb, ebusy, edone, epass} = {4'b0000, pass_l[g]};
      end
      chk($sformatf("u%0d.a", g), a_o[g], ea);
      chk($sformatf("u%0d.b", g), b_o[g], eb);
      chk($sformatf("u%0d.busy", g), busy_o[g], ebusy);
      chk($sformatf("u%0d.done", g), done_o[g], edone);
      chk($sformatf("u%0d.pass", g), pass_o[g], epass);
      chk($sformatf("u%0d.vec_idx", g), vi_o[g], v);
      chk($sformatf("u%0d.err_mask", g), em_o[g], m);
      chk($sformatf("u%0d.err_count", g), ec_o[g], $countones(m));
      if (!rst_n) begin
        chk($sformatf("u%0d.rst_flags", g), {a_o[g], b_o[g], busy_o[g], done_o[g], pass_o[g]}, 0);
        chk($sformatf("u%0d.rst_regs", g), {ec_o[g], em_o[g], vi_o[g]}, 0);
      end
      if (lit_en[g] && done_o[g]) begin
        chk($sformatf("u%0d.lit_latency", g), kk, lit_lat[g]);
        chk($sformatf("u%0d.lit_mask", g), em_o[g], lit_mask[g]);
        chk($sformatf("u%0d.lit_count", g), ec_o[g], lit_cnt[g]);
        chk($sformatf("u%0d.lit_pass", g), pass_o[g], lit_pass[g]);
      end
    end
    if (fin_req) begin
      chk("timeouts", tmo, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
    end
  end
  task automatic cyc(input int c);
    repeat (c) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic good_tab(input int g);
    for (int i = 0; i < 4; i++) ftab[g][i] = gold(i);
  endtask
  task automatic lit(input int g, input int mk, input int c, input int p);
    lit_en[g] = 1'b1; lit_mask[g] = mk; lit_cnt[g] = c; lit_pass[g] = p; lit_lat[g] = 4 * hold(g);
  endtask
  task automatic go(input int g);
    start_i[g] = 1'b1;
    cyc(1);
    start_i[g] = 1'b0;
  endtask
  task automatic wait_done(input int g);
    int c = 0;
    while (!done_o[g] && c < 200) begin
      cyc(1);
      c++;
    end
    if (c >= 200) tmo++;
  endtask
  task automatic finish_run(input int g);
    wait_done(g);
    cyc(2);
    lit_en[g] = 1'b0;
  endtask
  initial begin
    start_i = '{1'b0, 1'b0};
    lit_en = '{1'b0, 1'b0};
    good_tab(0);
    good_tab(1);
    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    lit(0, 0, 0, 1);
    go(0);
    finish_run(0);
    for (int i = 0; i < 4; i++) ftab[0][i] = gold(i) | 3'b001;
    lit(0, 4'b1100, 2, 0);
    go(0);
    finish_run(0);
    for (int i = 0; i < 4; i++) ftab[0][i] = gold(i) & 3'b011;
    lit(0, 4'b1000, 1, 0);
    go(0);
    cyc(4);
    go(0);
    wait_done(0);
    go(0);
    cyc(2);
    lit_en[0] = 1'b0;
    good_tab(0);
    lit(0, 0, 0, 1);
    go(0);
    finish_run(0);
    go(0);
    cyc(9);
    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    good_tab(1);
    lit(1, 0, 0, 1);
    go(1);
    finish_run(1);
    repeat (30) begin
      int g, c;
      g = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++)
        ftab[g][i] = $urandom_range(0, 2) == 0 ? gold(i) ^ 3'($urandom_range(1, 7)) : gold(i);
      go(g);
      c = 0;
      while (busy_o[g] && c < 200) begin
        start_i[g] = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 99) == 0) begin
          #1 rst_n = 1'b0;
          cyc(1);
          rst_n = 1'b1;
        end else cyc(1);
        c++;
      end
      if (c >= 200) tmo++;
      start_i[g] = 1'b0;
      cyc(2);
    end
    fin_req = 1'b1;
    cyc(4);
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Self-checking truth-table sequencer for the 2-input AND/OR/NOT gate block. It sits on both sides of that block.
- Upstream, it drives the gate block's `a`/`b` inputs through all four input combinations, holding each for a fixed number of cycles.
- Downstream, it samples the gate block's 3-bit result `y` and compares it against the expected value.
- It accumulates a per-vector failure mask and error count, then reports pass/fail with a start/done handshake.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles each input vector is held; legal range 1..255.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  run request; sampled only in IDLE.
- `a`  output  1  registered stimulus to gate block input `a`.
- `b`  output  1  registered stimulus to gate block input `b`.
- `y_in`  input  3  gate block result: [2]=a&b, [1]=a|b, [0]=~a.
- `busy`  output  1  high in DRIVE and DONE.
- `done`  output  1  one-cycle pulse at end of run.
- `pass`  output  1  1 when the last completed run had zero mismatches.
- `err_count`  output  3  mismatching vectors in current/last run, 0..4.
- `err_mask`  output  4  bit i set when vector i mismatched.
- `vec_idx`  output  2  index of the vector currently driven.

## Operation
- States: IDLE, DRIVE, DONE.
- **IDLE**
  - `a`=`b`=0, `busy`=0.
  - `start`=1 → DRIVE; on that edge clear `vec_idx`, hold counter, `err_count` and `err_mask`.
- **DRIVE**
  - Drive {`a`,`b`} = {`vec_idx[1]`,`vec_idx[0]`}: vector 0=00, 1=01, 2=10, 3=11.
  - Hold counter runs 0..HOLD_CYCLES-1.
  - On the edge where counter == HOLD_CYCLES-1:
    - Compare `y_in` with expected {a&b, a|b, ~a}, computed from the registered `a`/`b`.
    - On mismatch: `err_count`+1 and set `err_mask[vec_idx]`.
    - If `vec_idx`==3 → DONE; else `vec_idx`+1 and counter ← 0.
- **DONE**
  - `done`=1 for exactly one cycle.
  - `pass` ← (final `err_count`==0), including the vector-3 result.
  - `a`=`b`=0 next cycle; → IDLE unconditionally.
- `start` while in DRIVE or DONE is ignored; it is not queued.
- `pass`, `err_count` and `err_mask` hold their values in IDLE until the next accepted `start`.
- Any bit difference in `y_in` counts as one mismatch for that vector, so `err_count` never exceeds 4.
- Only the sample-cycle value of `y_in` is checked; values in earlier hold cycles are don't-care (settling time).

## Timing
- Reset values (async, immediate on `rst_n`=0):
  - state IDLE.
  - `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `err_mask`=0, `vec_idx`=0, counter=0.
- Reset mid-run aborts with no `done` pulse; a new `start` is required after `rst_n` rises.
- Run timeline, where edge 0 is the edge sampling `start`=1 in IDLE and H = HOLD_CYCLES:
  - Vector i is valid on `a`/`b` from edge i·H to edge (i+1)·H.
  - Vector i is sampled at edge (i+1)·H.
  - `done`=1 between edges 4H and 4H+1; `busy` falls after edge 4H+1.
- Start-to-done latency is 4H cycles; the minimum is 4 with H=1.
- `busy` rises at edge 0.
- `err_count` and `err_mask` update at the sample edge and are visible the following cycle.
- `a`/`b` are driven directly from flops, with no combinational path from `y_in`.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 cycles → every output at its reset value, including `pass`=0.
- **Correct gate block, H=4:** pulse `start` → `a`/`b` sequence 00,01,10,11 with 4 cycles each; `done` 16 cycles after start; `pass`=1, `err_count`=0, `err_mask`=0000.
- **`y_in[0]` stuck at 1:** vectors 2 and 3 fail → `err_mask`=1100, `err_count`=2, `pass`=0.
- **`y_in[2]` stuck at 0:** only vector 3 fails → `err_mask`=1000, `err_count`=1, `pass`=0.
- **Start handling:** pulse `start` again at cycle 5 of a run and during the DONE cycle → both ignored, exactly one `done` pulse. Then a `start` in IDLE begins a new run and clears `err_mask`/`err_count` from the previous failing run.
- **Reset mid-run:** assert `rst_n`=0 during vector 2 → outputs return to reset values at once and no `done` pulse occurs. A subsequent run with H=1 completes in 4 cycles with `pass`=1.
